entry_conv_ctrl: RTL and testbench

//  Parametrised entry/convert/display sequencer between debounced buttons, the hex-digit switches,
//  the IEEE754 converter FSM and the 7-segment controller. Collects up to DIGITS hex digits,

---
 rtl/entry_conv_pkg.sv | 21 ++
 rtl/digit_shift_reg.sv | 51 +++++
 rtl/entry_conv_ctrl.sv | 159 +++++++++++++++
 tb/tb_entry_conv_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/entry_conv_pkg.sv
// Shared types and constants for the entry/convert/display sequencer.
package entry_conv_pkg;

  typedef enum logic [1:0] {
    ENTRY,
    BUSY,
    SHOW,
    ERR
  } state_t;

  localparam logic MODE_HALF   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  localparam int RES_DIGITS_HALF   = 4;
  localparam int RES_DIGITS_SINGLE = 8;

  function automatic logic [15:0] res_mask(input logic m);
    res_mask = (m == MODE_SINGLE) ? 16'h00FF : 16'h000F;
  endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Hex-digit entry register: left shift with saturation, single-digit load, clear.
module digit_shift_reg #(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_clr,
  input  logic                i_shift,
  input  logic                i_load,
  input  logic [3:0]          i_digit,
  output logic [4*DIGITS-1:0] o_num,
  output logic [DIGITS-1:0]   o_msk,
  output logic [4*DIGITS-1:0] o_num_nxt,
  output logic [DIGITS-1:0]   o_msk_nxt
);

  logic [4*DIGITS-1:0] r_num;
  logic [DIGITS-1:0]   r_msk;
  logic                w_full;

  assign w_full = &r_msk;
  assign o_num  = r_num;
  assign o_msk  = r_msk;

  // Next value is exported so the owner can register a copy in lockstep.
  always_comb begin
    o_num_nxt = r_num;
    o_msk_nxt = r_msk;
    if (i_clr) begin
      o_num_nxt = '0;
      o_msk_nxt = '0;
    end else if (i_load) begin
      o_num_nxt = {{(4*DIGITS-4){1'b0}}, i_digit};
      o_msk_nxt = DIGITS'(1);
    end else if (i_shift && !w_full) begin
      o_num_nxt = {r_num[4*DIGITS-5:0], i_digit};
      o_msk_nxt = {r_msk[DIGITS-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_num <= '0;
      r_msk <= '0;
    end else begin
      r_num <= o_num_nxt;
      r_msk <= o_msk_nxt;
    end
  end

endmodule

// File: rtl/entry_conv_ctrl.sv
// Entry/convert/display sequencer between buttons, IEEE754 converter
// and 7-segment controller.
module entry_conv_ctrl #(
  parameter int DIGITS  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enter,
  input  logic [3:0]          digit,
  input  logic                confirm,
  input  logic                mode,
  output logic [4*DIGITS-1:0] conv_data,
  output logic                conv_mode,
  output logic                conv_start,
  output logic                conv_reset,
  input  logic                conv_done,
  input  logic                conv_error,
  input  logic [31:0]         conv_result,
  output logic [4*DIGITS-1:0] show,
  output logic [DIGITS-1:0]   mask,
  output logic                error,
  output logic                busy
);

  import entry_conv_pkg::*;

  localparam int NW = 4 * DIGITS;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  if (DIGITS < 8 || DIGITS > 16) begin : g_bad_digits
    $error("entry_conv_ctrl: DIGITS must be in 8..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("entry_conv_ctrl: TIMEOUT must be >= 2");
  end

  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic [NW-1:0]     w_num;
  logic [NW-1:0]     w_num_nxt;
  logic [DIGITS-1:0] w_msk;
  logic [DIGITS-1:0] w_msk_nxt;
  logic              w_shift;
  logic              w_load;
  logic              w_go;
  logic [NW-1:0]     w_res_show;
  logic [15:0]       w_res_m16;
  logic [DIGITS-1:0] w_res_mask;

  assign w_shift = enter & ~clear & (r_state == ENTRY);
  assign w_load  = enter & ~clear & (r_state == SHOW);
  // Enter wins over a simultaneous confirm.
  assign w_go    = confirm & ~enter & ~clear
                 & (r_state == ENTRY) & (|w_msk);

  assign w_res_show = (conv_mode == MODE_SINGLE)
                    ? NW'(conv_result)
                    : NW'(conv_result[15:0]);
  assign w_res_m16  = res_mask(conv_mode);
  assign w_res_mask = w_res_m16[DIGITS-1:0];

  assign conv_data = w_num;

  digit_shift_reg #(.DIGITS(DIGITS)) u_dsr (
    .clk       (clk),
    .i_reset   (reset),
    .i_clr     (clear),
    .i_shift   (w_shift),
    .i_load    (w_load),
    .i_digit   (digit),
    .o_num     (w_num),
    .o_msk     (w_msk),
    .o_num_nxt (w_num_nxt),
    .o_msk_nxt (w_msk_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ENTRY;
      r_cnt      <= '0;
      conv_mode  <= 1'b0;
      conv_start <= 1'b0;
      conv_reset <= 1'b0;
      show       <= '0;
      mask       <= '0;
      error      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      conv_reset <= 1'b0;
      if (clear) begin
        r_state    <= ENTRY;
        r_cnt      <= '0;
        conv_reset <= 1'b1;
        show       <= '0;
        mask       <= '0;
        error      <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (r_state)
          ENTRY: begin
            show <= w_num_nxt;
            mask <= w_msk_nxt;
            if (w_go) begin
              r_state    <= BUSY;
              r_cnt      <= '0;
              conv_mode  <= mode;
              conv_start <= 1'b1;
              busy       <= 1'b1;
            end
          end
          BUSY: begin
            // A done in the timeout cycle still counts as done.
            if (conv_done && !conv_error) begin
              r_state <= SHOW;
              r_cnt   <= '0;
              busy    <= 1'b0;
              show    <= w_res_show;
              mask    <= w_res_mask;
            end else if (conv_done) begin
              r_state <= ERR;
              r_cnt   <= '0;
              busy    <= 1'b0;
              error   <= 1'b1;
              show    <= '0;
              mask    <= '0;
            end else if (r_cnt == CNT_LAST) begin
              r_state    <= ERR;
              r_cnt      <= '0;
              busy       <= 1'b0;
              error      <= 1'b1;
              show       <= '0;
              mask       <= '0;
              conv_reset <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          SHOW: begin
            if (enter) begin
              r_state <= ENTRY;
              show    <= w_num_nxt;
              mask    <= w_msk_nxt;
            end
          end
          ERR: begin
            error <= 1'b1;
          end
          default: r_state <= ENTRY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_entry_conv_ctrl.sv
// Directed bench for entry_conv_ctrl with an expected-result queue
// for conversion outcomes.
module tb_entry_conv_ctrl;

  localparam int DIGITS  = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset, clear, enter, confirm, mode;
  logic [3:0]  digit;
  logic        conv_done, conv_error;
  logic [31:0] conv_result;
  logic [31:0] conv_data, show;
  logic [7:0]  mask;
  logic        conv_mode, conv_start, conv_reset, error, busy;

  typedef struct {
    logic [31:0] show;
    logic [7:0]  mask;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc;
  int rst_pulses;

  entry_conv_ctrl #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .enter       (enter),
    .digit       (digit),
    .confirm     (confirm),
    .mode        (mode),
    .conv_data   (conv_data),
    .conv_mode   (conv_mode),
    .conv_start  (conv_start),
    .conv_reset  (conv_reset),
    .conv_done   (conv_done),
    .conv_error  (conv_error),
    .conv_result (conv_result),
    .show        (show),
    .mask        (mask),
    .error       (error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic go(input logic m);
    mode    = m;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
  endtask

  task automatic push(input logic [31:0] s, input logic [7:0] m,
                      input logic e);
    exp_t x;
    x.show = s;
    x.mask = m;
    x.err  = e;
    q.push_back(x);
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, got show %0h", tag, show);
    end else begin
      x = q.pop_front();
      chk({tag, ".show"}, 64'(show), 64'(x.show));
      chk({tag, ".mask"}, 64'(mask), 64'(x.mask));
      chk({tag, ".err"},  64'(error), 64'(x.err));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".show"}, 64'(show), 64'h0);
    chk({tag, ".mask"}, 64'(mask), 64'h0);
    chk({tag, ".err"},  64'(error), 64'h0);
    chk({tag, ".busy"}, 64'(busy), 64'h0);
    chk({tag, ".data"}, 64'(conv_data), 64'h0);
    chk({tag, ".start"}, 64'(conv_start), 64'h0);
    chk({tag, ".crst"}, 64'(conv_reset), 64'h0);
    chk({tag, ".cmode"}, 64'(conv_mode), 64'h0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; enter = 1'b0; confirm = 1'b0;
    mode = 1'b0; digit = 4'h0; conv_done = 1'b0; conv_error = 1'b0;
    conv_result = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    chk_idle("rst");

    // 1: four digits, then reset
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t1.show", 64'(show), 64'h1234);
    chk("t1.mask", 64'(mask), 64'h0F);
    chk("t1.data", 64'(conv_data), 64'h1234);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle("t1.rst");

    // 2: saturation at DIGITS
    for (int i = 1; i <= 9; i++) press(4'(i));
    chk("t2.show", 64'(show), 64'h12345678);
    chk("t2.mask", 64'(mask), 64'hFF);

    // clear together with enter: clear wins
    clear = 1'b1; digit = 4'hE; enter = 1'b1;
    tick();
    clear = 1'b0; enter = 1'b0;
    chk("clr.crst", 64'(conv_reset), 64'h1);
    chk("clr.show", 64'(show), 64'h0);
    chk("clr.data", 64'(conv_data), 64'h0);
    tick();
    chk("clr.crst1", 64'(conv_reset), 64'h0);

    // 3: half conversion, upper result bits ignored
    press(4'hA); press(4'hB);
    chk("t3.mask0", 64'(mask), 64'h03);
    push(32'h00003C00, 8'h0F, 1'b0);
    go(1'b0);
    chk("t3.start", 64'(conv_start), 64'h1);
    chk("t3.busy0", 64'(busy), 64'h1);
    chk("t3.cmode", 64'(conv_mode), 64'h0);
    tick();
    chk("t3.start1", 64'(conv_start), 64'h0);
    chk("t3.busy1", 64'(busy), 64'h1);
    chk("t3.data", 64'(conv_data), 64'hAB);
    conv_done = 1'b1; conv_result = 32'hDEAD3C00;
    tick();
    conv_done = 1'b0;
    chk("t3.busy2", 64'(busy), 64'h0);
    pop_check("t3");
    go(1'b1);
    chk("show.confirm", 64'(conv_start), 64'h0);
    chk("show.hold", 64'(show), 64'h3C00);

    // 4: enter from SHOW restarts, then single conversion
    press(4'h7);
    chk("t4.show0", 64'(show), 64'h7);
    chk("t4.mask0", 64'(mask), 64'h1);
    chk("t4.data0", 64'(conv_data), 64'h7);
    push(32'h3F800000, 8'hFF, 1'b0);
    go(1'b1);
    chk("t4.cmode", 64'(conv_mode), 64'h1);
    chk("t4.start", 64'(conv_start), 64'h1);
    conv_done = 1'b1; conv_result = 32'h3F800000;
    tick();
    conv_done = 1'b0;
    pop_check("t4");

    // 5: timeout with inputs hammered during BUSY
    press(4'h5);
    push(32'h0, 8'h0, 1'b1);
    go(1'b0);
    digit = 4'hF; enter = 1'b1;
    cyc = 0;
    rst_pulses = 0;
    while (cyc < 40 && error !== 1'b1) begin
      tick();
      cyc++;
      if (conv_reset === 1'b1) rst_pulses++;
    end
    chk("t5.cycle", 64'(cyc), 64'(TIMEOUT));
    chk("t5.crst", 64'(conv_reset), 64'h1);
    chk("t5.busy", 64'(busy), 64'h0);
    chk("t5.data", 64'(conv_data), 64'h5);
    pop_check("t5");
    confirm = 1'b1;
    tick();
    enter = 1'b0; confirm = 1'b0;
    chk("t5.crst1", 64'(conv_reset), 64'h0);
    chk("t5.pulses", 64'(rst_pulses), 64'h1);
    chk("t5.start", 64'(conv_start), 64'h0);
    chk("t5.hold", 64'(error), 64'h1);
    chk("t5.data1", 64'(conv_data), 64'h5);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5.clr", 64'(error), 64'h0);
    chk("t5.clrc", 64'(conv_reset), 64'h1);

    // done in the same cycle as the timeout: done wins
    press(4'h2);
    push(32'h40000000, 8'hFF, 1'b0);
    go(1'b1);
    repeat (TIMEOUT - 1) tick();
    chk("dw.busy", 64'(busy), 64'h1);
    conv_done = 1'b1; conv_result = 32'h40000000;
    tick();
    conv_done = 1'b0;
    chk("dw.crst", 64'(conv_reset), 64'h0);
    pop_check("dw");

    // converter-reported error
    press(4'h1);
    push(32'h0, 8'h0, 1'b1);
    go(1'b0);
    conv_done = 1'b1; conv_error = 1'b1;
    tick();
    conv_done = 1'b0; conv_error = 1'b0;
    pop_check("cerr");
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // 6: clear mid-BUSY, late done ignored, empty confirm ignored
    press(4'h9);
    go(1'b0);
    tick();
    chk("t6.busy", 64'(busy), 64'h1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t6.crst", 64'(conv_reset), 64'h1);
    chk("t6.busy1", 64'(busy), 64'h0);
    conv_done = 1'b1; conv_result = 32'h1234;
    tick();
    conv_done = 1'b0;
    chk_idle("t6.late");
    go(1'b1);
    chk("t6.start", 64'(conv_start), 64'h0);
    chk("t6.busy2", 64'(busy), 64'h0);
    chk("t6.sb", 64'(q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
